// File: rtl/fsb_ser_pkg.sv
// Shared constants, packet type and sizing helper for the FSB packet word serializer.
package fsb_ser_pkg;

   localparam int unsigned FSB_WIDTH_C  = 80;
   localparam int unsigned WORD_WIDTH_C = 32;

   typedef logic [FSB_WIDTH_C-1:0] fsb_pkt_t;

   function automatic int unsigned words_per_pkt(input int unsigned fsb_w,
                                                 input int unsigned word_w);
      return (fsb_w + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/fsb_ser_fifo.sv
// Packet ring buffer: registered storage, wrap-bit pointers, full/empty flags and occupancy.
module fsb_ser_fifo
   import fsb_ser_pkg::*;
#(
   parameter int unsigned WIDTH = FSB_WIDTH_C,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     pipe_rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[PTR_W-2:0]];

   // Flush wins over any traffic in the same cycle; fullness is judged before the pop.
   assign push_ok = push_i & ~full_o & ~flush_i;
   assign pop_ok  = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[PTR_W-2:0]] <= data_i;
   end

endmodule

// File: rtl/fsb_pkt_word_serializer.sv
// Buffers FSB packets and hands them out as WORD_WIDTH words, last word zero-extended.
// Optional packet in/out counters are built when FSB_SER_STATS_EN is defined.
module fsb_pkt_word_serializer
   import fsb_ser_pkg::*;
#(
   parameter int unsigned FSB_WIDTH  = FSB_WIDTH_C,
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_C,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          pipe_rst_n,
   input  logic                          flush_i,
   input  logic                          fsb_v_i,
   input  logic [FSB_WIDTH-1:0]          fsb_data_i,
   output logic                          fsb_ready_o,
   output logic                          word_v_o,
   output logic [WORD_WIDTH-1:0]         word_data_o,
   output logic                          word_last_o,
   input  logic                          word_yumi_i,
   output logic [$clog2(FIFO_DEPTH):0]   pkt_count_o
`ifdef FSB_SER_STATS_EN
   ,
   output logic [31:0]                   pkts_in_o,
   output logic [31:0]                   pkts_out_o
`endif
);

   localparam int unsigned WPP   = words_per_pkt(FSB_WIDTH, WORD_WIDTH);
   localparam int unsigned IDX_W = (WPP > 1) ? $clog2(WPP) : 1;

   logic [FSB_WIDTH-1:0]      head_data;
   logic [WPP*WORD_WIDTH-1:0] head_ext;
   logic [WORD_WIDTH-1:0]     word_arr [WPP];
   logic                      full, empty;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      is_last, pop_word, pop_pkt, push_ok;

   fsb_ser_fifo #(
      .WIDTH (FSB_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .pipe_rst_n (pipe_rst_n),
      .flush_i    (flush_i),
      .push_i     (fsb_v_i),
      .data_i     (fsb_data_i),
      .pop_i      (pop_pkt),
      .head_o     (head_data),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (pkt_count_o)
   );

   assign fsb_ready_o = ~full;
   assign word_v_o    = ~empty;
   assign is_last     = (idx_q == IDX_W'(WPP - 1));
   assign word_last_o = word_v_o & is_last;
   assign pop_word    = word_yumi_i & word_v_o;
   assign pop_pkt     = pop_word & is_last;
   assign push_ok     = fsb_v_i & fsb_ready_o & ~flush_i;

   // Pad the head packet to whole words so the final word comes out zero-extended.
   always_comb begin
      head_ext = '0;
      head_ext[FSB_WIDTH-1:0] = head_data;
      for (int k = 0; k < int'(WPP); k++) begin
         word_arr[k] = head_ext[k*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   assign word_data_o = empty ? '0 : word_arr[idx_q];

   always_comb begin
      idx_d = idx_q;
      if (flush_i) begin
         idx_d = '0;
      end else if (pop_word) begin
         idx_d = is_last ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) idx_q <= '0;
      else             idx_q <= idx_d;
   end

`ifdef FSB_SER_STATS_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         pkts_in_o  <= '0;
         pkts_out_o <= '0;
      end else begin
         if (push_ok)                pkts_in_o  <= pkts_in_o + 1'b1;
         if (pop_pkt && !flush_i)    pkts_out_o <= pkts_out_o + 1'b1;
      end
   end
`else
   logic unused_push_ok;
   assign unused_push_ok = push_ok;
`endif

`ifndef SYNTHESIS
   yumi_needs_valid: assert property (@(posedge clk) disable iff (!pipe_rst_n)
                                      word_yumi_i |-> word_v_o)
      else $error("word_yumi_i asserted while word_v_o is low");
`endif

endmodule

// File: doc/fsb_pkt_word_serializer.md
Name: fsb_pkt_word_serializer

Overview:
- Downstream stage of the FSB client node output on the AXI-L slave path.
- Buffers 80-bit FSB packets from the client's valid/ready output channel.
- Serializes each packet into 32-bit words for the AXI-L read-data logic in the OCL adapter.
- Reports the buffered-packet count so host software can poll before reading.

Parameters:
FSB_WIDTH, 80, FSB packet width in bits
WORD_WIDTH, 32, output word width in bits
FIFO_DEPTH, 8, packet buffer depth; power of 2, minimum 2

Ports:
clk  in  1  clock
pipe_rst_n  in  1  reset; asynchronous, active-low
flush_i  in  1  synchronous flush of all buffered packets
fsb_v_i  in  1  packet valid from FSB client
fsb_data_i  in  FSB_WIDTH  packet data
fsb_ready_o  out  1  packet accepted when fsb_v_i & fsb_ready_o
word_v_o  out  1  word available
word_data_o  out  WORD_WIDTH  current word
word_last_o  out  1  current word is the final word of its packet
word_yumi_i  in  1  consumer takes the word; legal only when word_v_o=1
pkt_count_o  out  $clog2(FIFO_DEPTH)+1  packets buffered, including the one being serialized

Behaviour:
- Reset: clock clk; reset pipe_rst_n, asynchronous, active-low.
- Values while and after reset: write ptr = 0, read ptr = 0, word index = 0.
  - word_v_o = 0, word_last_o = 0, word_data_o = 0.
  - pkt_count_o = 0, fsb_ready_o = 1.
- Words per packet: WPP = ceil(FSB_WIDTH/WORD_WIDTH); 3 at defaults.
- Word k = fsb_data[k*WORD_WIDTH +: WORD_WIDTH].
  - The final word is zero-extended; at defaults word2 = {16'h0, data[79:64]}.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - empty: ptrs equal.
  - full: MSBs differ and the rest are equal.
- fsb_ready_o = !full. No same-cycle bypass: when full, a push is refused even if a final-word pop occurs that cycle.
- Latency: a packet accepted at edge N gives word_v_o = 1 in cycle N+1 if the FIFO was empty. Output is first-word-fall-through from registered storage.
- word_v_o = !empty.
- word_data_o selects from the head packet by the word index; 0 when empty.
- word_last_o = word_v_o & (index == WPP-1).
- On word_yumi_i:
  - Not last word: index += 1.
  - Last word: index <= 0 and read ptr += 1.
- A yumi with word_v_o = 0 is ignored. A sim-only assertion fires on it.
- Simultaneous push and last-word pop when not full: both occur; count is unchanged.
- pkt_count_o = wr_ptr - rd_ptr, registered-state derived; range 0..FIFO_DEPTH.
- flush_i:
  - Next edge: ptrs = 0, index = 0.
  - Overrides a push or pop in the same cycle; the packet offered that cycle is dropped and fsb_ready_o stays 1.
- Reset mid-packet: partially read packet discarded; index returns to 0.

Optional Feature:
- Macro: FSB_SER_STATS_EN.
- With the macro, two extra ports are added:
  - pkts_in_o (32 bits): increments on each accepted packet.
  - pkts_out_o (32 bits): increments on each last-word pop.
  - Both wrap modulo 2^32, are cleared by reset, and are not cleared by flush_i.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fsb_ser_pkg:
  - FSB_WIDTH_C = 80, WORD_WIDTH_C = 32.
  - Function words_per_pkt(fsb_w, word_w).
  - Typedef fsb_pkt_t (logic [79:0]).
- One sub-module fsb_ser_fifo holds the ring-buffer storage, pointers, full/empty and count.
- The top holds the word-index counter, word select and stats counters.

Test Plan:
- Single packet 80'h1234_89ABCDEF_01234567 -> three words, last asserted on the third only:
  - 32'h01234567
  - 32'h89ABCDEF
  - 32'h00001234
  - pkt_count_o 1 -> 0 after the third yumi.
- Push 8 packets with no yumi -> fsb_ready_o = 0 after the 8th and pkt_count_o = 8. A 9th offered packet is not taken. Draining returns words in order.
- Full FIFO, last-word yumi with fsb_v_i = 1 in the same cycle -> push refused that cycle, accepted next cycle, count 8 -> 7 -> 8.
- Steady stream: a push every cycle and a yumi every cycle -> no words lost or duplicated over 100 packets; the pointers wrap past the FIFO depth many times.
- Mid-packet, after one yumi, assert flush_i with fsb_v_i = 1 -> next cycle word_v_o = 0, pkt_count_o = 0, offered packet dropped.
- With FSB_SER_STATS_EN: 5 pushes then 5 drains -> pkts_in_o = 5 and pkts_out_o = 5. Both unchanged by flush_i and zeroed by pipe_rst_n.
